// File: rtl/wb_commit_cp0.sv
// wb_commit_cp0 -- writeback / commit stage.
//   Reads the MEM/WB bundle, drives the register-file write port, owns HI/LO
//   and CP0 Status(12)/Cause(13)/EPC(14), and raises a flush + PC redirect on
//   an exception or ERET. It then sits in TRAP for FLUSH_CYCLES cycles.
//   Optional macro EXT_INT_EN enables external interrupts.
// Ports:
//   clock, reset          rising edge, synchronous active-high reset
//   WB_*                  control/datapath bundle from MEM/WB
//   md_we/md_hi/md_lo     multiply/divide result
//   ext_int[5:0]          external interrupt lines
//   rf_we/rf_waddr/rf_wdata  register-file write port (combinational)
//   hi_q, lo_q, status_q, cause_q, epc_q  architectural state
//   flush, redirect_valid, redirect_pc    one-cycle redirect
//   in_trap               high while in TRAP
module wb_commit_cp0 #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_F000,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        WB_RegWrite,
  input  logic        WB_MemIOtoReg,
  input  logic        WB_Mfhi,
  input  logic        WB_Mflo,
  input  logic        WB_Mthi,
  input  logic        WB_Mtlo,
  input  logic        WB_Jal,
  input  logic        WB_Jalr,
  input  logic        WB_Bgezal,
  input  logic        WB_Bltzal,
  input  logic        WB_Negative,
  input  logic        WB_Overflow,
  input  logic        WB_Divide_zero,
  input  logic        WB_Syscall,
  input  logic        WB_Break,
  input  logic        WB_Reserved_intruction,
  input  logic        WB_Eret,
  input  logic        WB_Mfc0,
  input  logic        WB_Mtc0,
  input  logic [31:0] WB_opcplus4,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_ALU_Result,
  input  logic [31:0] WB_MemData,
  input  logic [31:0] WB_rt_value,
  input  logic [4:0]  WB_waddr,
  input  logic [4:0]  WB_rd,
  input  logic        md_we,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  input  logic [5:0]  ext_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [31:0] status_q,
  output logic [31:0] cause_q,
  output logic [31:0] epc_q,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        in_trap
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] TRAP = 1'b1;
  localparam logic [2:0] CNT_LAST = 3'(FLUSH_CYCLES - 1);

  logic [0:0]  state;
  logic [2:0]  cnt;
  logic        iv, run, link, sync_exc, int_req, exc, commit, eret_take;
  logic [4:0]  exc_code;
  logic [31:0] cp0_rdata;
  logic [5:0]  int_lines;

  assign iv   = (WB_opcplus4 != 32'd0);
  assign run  = (state == RUN);
  assign link = WB_Jal | WB_Jalr | (WB_Bgezal & ~WB_Negative) | (WB_Bltzal & WB_Negative);

`ifdef EXT_INT_EN
  assign int_lines = ext_int;
  // Uses the current (pre-update) Status, so a same-cycle Mtc0 has no effect.
  assign int_req   = status_q[0] & |(status_q[15:10] & ext_int);
`else
  assign int_lines = 6'd0;
  assign int_req   = 1'b0;
`endif

  assign sync_exc  = WB_Reserved_intruction | WB_Syscall | WB_Break |
                     WB_Overflow | WB_Divide_zero;
  assign exc       = iv & run & ~status_q[1] & (sync_exc | int_req);
  assign commit    = iv & run & ~exc;
  assign eret_take = commit & WB_Eret;

  always_comb begin
    exc_code = 5'd0;
    if      (WB_Reserved_intruction) exc_code = 5'd10;
    else if (WB_Syscall)             exc_code = 5'd8;
    else if (WB_Break)               exc_code = 5'd9;
    else if (WB_Overflow)            exc_code = 5'd12;
    else if (WB_Divide_zero)         exc_code = 5'd7;
  end

  always_comb begin
    case (WB_rd)
      5'd12:   cp0_rdata = status_q;
      5'd13:   cp0_rdata = cause_q;
      5'd14:   cp0_rdata = epc_q;
      default: cp0_rdata = 32'd0;
    endcase
  end

  always_comb begin
    if      (link)          rf_wdata = WB_opcplus4;
    else if (WB_Mfhi)       rf_wdata = hi_q;
    else if (WB_Mflo)       rf_wdata = lo_q;
    else if (WB_Mfc0)       rf_wdata = cp0_rdata;
    else if (WB_MemIOtoReg) rf_wdata = WB_MemData;
    else                    rf_wdata = WB_ALU_Result;
  end

  assign rf_waddr = WB_Jal ? 5'd31 : WB_waddr;
  assign rf_we    = ~reset & commit & (WB_RegWrite | link) & (rf_waddr != 5'd0);
  assign in_trap  = (state == TRAP);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      cnt            <= 3'd0;
      hi_q           <= 32'd0;
      lo_q           <= 32'd0;
      status_q       <= 32'd0;
      cause_q        <= 32'd0;
      epc_q          <= 32'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      flush          <= 1'b0;
      redirect_valid <= 1'b0;

      if (commit) begin
        if (WB_Mthi) hi_q <= WB_ALU_Result;
        if (WB_Mtlo) lo_q <= WB_ALU_Result;
        if (md_we) begin
          hi_q <= md_hi;
          lo_q <= md_lo;
        end
        if (WB_Mtc0) begin
          case (WB_rd)
            5'd12:   status_q <= WB_rt_value;
            5'd13:   cause_q  <= WB_rt_value;
            5'd14:   epc_q    <= WB_rt_value;
            default: ;
          endcase
        end
        if (WB_Eret) status_q[1] <= 1'b0;
      end

      if (exc) begin
        epc_q         <= sync_exc ? WB_PC : WB_opcplus4;
        cause_q[6:2]  <= exc_code;
        status_q[1]   <= 1'b1;
      end

      // Pending-interrupt field tracks the lines every cycle, overriding any Mtc0.
      cause_q[15:10] <= int_lines;

      case (state)
        RUN: begin
          if (exc | eret_take) begin
            state          <= TRAP;
            cnt            <= 3'd0;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            redirect_pc    <= exc ? EXC_VECTOR : epc_q;
          end
        end
        default: begin
          if (cnt == CNT_LAST) state <= RUN;
          else                 cnt   <= cnt + 3'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_commit_cp0.sv
module tb_wb_commit_cp0;
  logic        clock = 1'b0;
  logic        reset;
  logic        RegWrite, MemIOtoReg, Mfhi, Mflo, Mthi, Mtlo;
  logic        Jal, Jalr, Bgezal, Bltzal, Negative;
  logic        Overflow, Divide_zero, Syscall, Break, RI, Eret, Mfc0, Mtc0;
  logic [31:0] opcplus4, pc, alu, memdata, rt_value;
  logic [4:0]  waddr, rd;
  logic        md_we;
  logic [31:0] md_hi, md_lo;
  logic [5:0]  ext_int;
  logic        rf_we, flush, redirect_valid, in_trap;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q, status_q, cause_q, epc_q, redirect_pc;

  wb_commit_cp0 dut (
    .clock(clock), .reset(reset),
    .WB_RegWrite(RegWrite), .WB_MemIOtoReg(MemIOtoReg), .WB_Mfhi(Mfhi), .WB_Mflo(Mflo),
    .WB_Mthi(Mthi), .WB_Mtlo(Mtlo), .WB_Jal(Jal), .WB_Jalr(Jalr), .WB_Bgezal(Bgezal),
    .WB_Bltzal(Bltzal), .WB_Negative(Negative), .WB_Overflow(Overflow),
    .WB_Divide_zero(Divide_zero), .WB_Syscall(Syscall), .WB_Break(Break),
    .WB_Reserved_intruction(RI), .WB_Eret(Eret), .WB_Mfc0(Mfc0), .WB_Mtc0(Mtc0),
    .WB_opcplus4(opcplus4), .WB_PC(pc), .WB_ALU_Result(alu), .WB_MemData(memdata),
    .WB_rt_value(rt_value), .WB_waddr(waddr), .WB_rd(rd),
    .md_we(md_we), .md_hi(md_hi), .md_lo(md_lo), .ext_int(ext_int),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi_q(hi_q), .lo_q(lo_q),
    .status_q(status_q), .cause_q(cause_q), .epc_q(epc_q), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_trap(in_trap)
  );

  always #5 clock = ~clock;

  localparam int S_WE = 0, S_WADDR = 1, S_WDATA = 2, S_HI = 3, S_LO = 4, S_STATUS = 5,
                 S_CAUSE = 6, S_EPC = 7, S_FLUSH = 8, S_RV = 9, S_RPC = 10, S_TRAP = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      S_WE:     return {31'd0, rf_we};
      S_WADDR:  return {27'd0, rf_waddr};
      S_WDATA:  return rf_wdata;
      S_HI:     return hi_q;
      S_LO:     return lo_q;
      S_STATUS: return status_q;
      S_CAUSE:  return cause_q;
      S_EPC:    return epc_q;
      S_FLUSH:  return {31'd0, flush};
      S_RV:     return {31'd0, redirect_valid};
      S_RPC:    return redirect_pc;
      default:  return {31'd0, in_trap};
    endcase
  endfunction

  always @(negedge clock) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [31:0] act;
        act = get_sig(q[i].sig);
        n_cmp++;
        if (act !== q[i].val) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", q[i].name, cyc, act, q[i].val);
        end
        q.delete(i);
      end
    end
  end

  task automatic expect_at(int ofs, int sig, logic [31:0] v, string name);
    exp_t e;
    e.cyc = cyc + ofs; e.sig = sig; e.val = v; e.name = name;
    q.push_back(e);
  endtask

  task automatic clr();
    {RegWrite, MemIOtoReg, Mfhi, Mflo, Mthi, Mtlo} = '0;
    {Jal, Jalr, Bgezal, Bltzal, Negative} = '0;
    {Overflow, Divide_zero, Syscall, Break, RI, Eret, Mfc0, Mtc0} = '0;
    opcplus4 = 0; pc = 0; alu = 0; memdata = 0; rt_value = 0;
    waddr = 0; rd = 0; md_we = 0; md_hi = 0; md_lo = 0;
  endtask

  task automatic step();
    @(posedge clock); #1;
    clr();
  endtask

  initial begin
    clr(); ext_int = 0; reset = 1;
    step(); step();
    reset = 0;
    expect_at(0, S_HI, 0, "rst_hi");
    expect_at(0, S_STATUS, 0, "rst_status");
    expect_at(0, S_TRAP, 0, "rst_trap");
    expect_at(0, S_RV, 0, "rst_rv");

    step(); RegWrite = 1; waddr = 5; alu = 32'h1234; opcplus4 = 32'h104;
    expect_at(0, S_WE, 1, "add_we");
    expect_at(0, S_WADDR, 5, "add_waddr");
    expect_at(0, S_WDATA, 32'h1234, "add_wdata");
    #1;
    n_cmp++;
    if (rf_we !== 1'b1) begin
      n_bad++; $display("FAIL add_we_direct: got %b", rf_we);
    end
    n_cmp++;
    if (rf_wdata !== 32'h1234) begin
      n_bad++; $display("FAIL add_wdata_direct: got %h", rf_wdata);
    end

    step(); RegWrite = 1; waddr = 0; alu = 32'h77; opcplus4 = 32'h108;
    expect_at(0, S_WE, 0, "r0_we");

    step(); Jal = 1; opcplus4 = 32'h208; alu = 32'h55;
    expect_at(0, S_WE, 1, "jal_we");
    expect_at(0, S_WADDR, 31, "jal_waddr");
    expect_at(0, S_WDATA, 32'h208, "jal_wdata");
    #1;
    n_cmp++;
    if (rf_waddr !== 5'd31) begin
      n_bad++; $display("FAIL jal_waddr_direct: got %0d", rf_waddr);
    end
    step(); Bltzal = 1; Negative = 0; waddr = 31; opcplus4 = 32'h20c;
    expect_at(0, S_WE, 0, "bltzal_we");

    step(); Mthi = 1; alu = 32'hAAAA; opcplus4 = 32'h300;
    expect_at(1, S_HI, 32'hAAAA, "mthi");
    step(); Mtlo = 1; alu = 32'h5555; opcplus4 = 32'h304;
    expect_at(1, S_LO, 32'h5555, "mtlo");
    expect_at(1, S_HI, 32'hAAAA, "mtlo_hi_kept");
    step(); md_we = 1; md_hi = 1; md_lo = 2; Mthi = 1; alu = 32'h9999; opcplus4 = 32'h308;
    expect_at(1, S_HI, 1, "md_hi");
    expect_at(1, S_LO, 2, "md_lo");
    step(); Mfhi = 1; RegWrite = 1; waddr = 7; opcplus4 = 32'h30c;
    expect_at(0, S_WE, 1, "mfhi_we");
    expect_at(0, S_WDATA, 1, "mfhi_wdata");
    #1;
    n_cmp++;
    if (rf_wdata !== 32'd1) begin
      n_bad++; $display("FAIL mfhi_wdata_direct: got %h", rf_wdata);
    end

    step(); Overflow = 1; RegWrite = 1; waddr = 3; pc = 32'h300; opcplus4 = 32'h304;
    expect_at(0, S_WE, 0, "ov_we");
    expect_at(1, S_EPC, 32'h300, "ov_epc");
    expect_at(1, S_CAUSE, 32'h30, "ov_cause");
    expect_at(1, S_STATUS, 32'h2, "ov_status");
    expect_at(1, S_FLUSH, 1, "ov_flush");
    expect_at(1, S_RV, 1, "ov_rv");
    expect_at(1, S_RPC, 32'hF000, "ov_rpc");
    expect_at(1, S_TRAP, 1, "trap1");
    expect_at(2, S_TRAP, 1, "trap2");
    expect_at(2, S_FLUSH, 0, "flush_once");
    expect_at(3, S_TRAP, 1, "trap3");
    expect_at(4, S_TRAP, 0, "trap_exit");
    expect_at(4, S_HI, 1, "trap_hi_kept");
    #1;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_bad++; $display("FAIL ov_we_direct: got %b", rf_we);
    end
    for (int k = 0; k < 3; k++) begin
      step(); RegWrite = 1; waddr = 9; Mthi = 1; alu = 32'hDEAD; opcplus4 = 32'h400;
      expect_at(0, S_WE, 0, "trap_we");
    end

    step(); Mtc0 = 1; rd = 14; rt_value = 32'h400; opcplus4 = 32'h404;
    expect_at(1, S_EPC, 32'h400, "mtc0_epc");
    step(); Eret = 1; opcplus4 = 32'h408;
    expect_at(1, S_STATUS, 0, "eret_status");
    expect_at(1, S_RV, 1, "eret_rv");
    expect_at(1, S_RPC, 32'h400, "eret_rpc");
    step(); step(); step();

    step(); Syscall = 1; Eret = 1; pc = 32'h600; opcplus4 = 32'h604;
    expect_at(1, S_CAUSE, 32'h20, "sys_cause");
    expect_at(1, S_STATUS, 32'h2, "sys_status");
    expect_at(1, S_EPC, 32'h600, "sys_epc");
    expect_at(1, S_RPC, 32'hF000, "sys_rpc");
    step(); step(); step();

    step(); Mfc0 = 1; RegWrite = 1; waddr = 8; rd = 12; opcplus4 = 32'h700;
    expect_at(0, S_WDATA, 32'h2, "mfc0_status");
    step(); Mfc0 = 1; RegWrite = 1; waddr = 8; rd = 5; opcplus4 = 32'h704;
    expect_at(0, S_WDATA, 0, "mfc0_other");

    step(); Mtc0 = 1; rd = 12; rt_value = 32'h0401; opcplus4 = 32'h708;
    expect_at(1, S_STATUS, 32'h0401, "mtc0_status");
    step(); ext_int = 6'b000001; pc = 32'h500; opcplus4 = 32'h504; RegWrite = 1; waddr = 4;
`ifdef EXT_INT_EN
    expect_at(0, S_WE, 0, "int_we");
    expect_at(1, S_EPC, 32'h504, "int_epc");
    expect_at(1, S_CAUSE, 32'h400, "int_cause");
    expect_at(1, S_STATUS, 32'h0403, "int_status");
    expect_at(1, S_RV, 1, "int_rv");
    expect_at(1, S_RPC, 32'hF000, "int_rpc");
`else
    expect_at(0, S_WE, 1, "noint_we");
    expect_at(1, S_RV, 0, "noint_rv");
    expect_at(1, S_EPC, 32'h600, "noint_epc");
    expect_at(1, S_CAUSE, 32'h20, "noint_cause");
`endif

    step(); reset = 1; ext_int = 0; RegWrite = 1; waddr = 6; opcplus4 = 32'h800;
    expect_at(0, S_WE, 0, "rst_we");
    expect_at(1, S_TRAP, 0, "rst2_trap");
    expect_at(1, S_STATUS, 0, "rst2_status");
    expect_at(1, S_EPC, 0, "rst2_epc");
    step(); reset = 0; RegWrite = 1; waddr = 6; alu = 32'h66; opcplus4 = 32'h804;
    expect_at(0, S_WE, 1, "post_rst_we");

    step(); step(); step();
    foreach (q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: expectation never checked (due cyc %0d)", q[i].name, q[i].cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
